// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter: instruction-fetch port and data port.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic [31:0]       d_rdata;
    logic              d_ack;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  if_rdata, if_ack, d_rdata, d_ack
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output if_rdata, if_ack, d_rdata, d_ack
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous 32-bit SRAM between a fetch port and a data port,
// generating multi-cycle read/write strobes and driving the tri-state data bus.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk_10M,
    input  logic              reset_of_clk10M,
    sram_port_arbiter_if.slave bus,
    output logic              busy,
    inout  wire  [31:0]       sram_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last_grant_d, last_grant_d_nxt;
    logic              gnt_d, gnt_d_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [3:0]        be_q, be_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              take_d;
    logic              cap_if, cap_d;
    logic              drive_q, drive_nxt;
    logic              ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic [3:0]        be_n_nxt;
    logic              if_ack_nxt, d_ack_nxt;

    // Bus is driven only during the three write phases.
    assign sram_data = drive_q ? wdata_q : 32'hzzzz_zzzz;

    // State, latched payload and registered pin/ack outputs.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_grant_d <= 1'b0;
            gnt_d        <= 1'b0;
            wdata_q      <= '0;
            be_q         <= 4'h0;
            drive_q      <= 1'b0;
            sram_addr    <= '0;
            sram_be_n    <= 4'hF;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            busy         <= 1'b0;
            bus.if_ack   <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            last_grant_d <= last_grant_d_nxt;
            gnt_d        <= gnt_d_nxt;
            wdata_q      <= wdata_nxt;
            be_q         <= be_nxt;
            drive_q      <= drive_nxt;
            sram_addr    <= addr_nxt;
            sram_be_n    <= be_n_nxt;
            sram_ce_n    <= ce_n_nxt;
            sram_oe_n    <= oe_n_nxt;
            sram_we_n    <= we_n_nxt;
            busy         <= (state_nxt != S_IDLE);
            bus.if_ack   <= if_ack_nxt;
            bus.d_ack    <= d_ack_nxt;
            if (cap_if) bus.if_rdata <= sram_data;
            if (cap_d)  bus.d_rdata  <= sram_data;
        end
    end

    // Next-state, arbitration and next-output decode.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        last_grant_d_nxt = last_grant_d;
        gnt_d_nxt        = gnt_d;
        wdata_nxt        = wdata_q;
        be_nxt           = be_q;
        addr_nxt         = sram_addr;
        take_d           = 1'b0;
        cap_if           = 1'b0;
        cap_d            = 1'b0;
        ce_n_nxt         = 1'b1;
        oe_n_nxt         = 1'b1;
        we_n_nxt         = 1'b1;
        be_n_nxt         = 4'hF;
        drive_nxt        = 1'b0;
        if_ack_nxt       = 1'b0;
        d_ack_nxt        = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On contention data wins unless it took the previous grant.
                    take_d           = bus.d_req && !(bus.if_req && last_grant_d);
                    gnt_d_nxt        = take_d;
                    last_grant_d_nxt = take_d;
                    cnt_nxt          = '0;
                    if (take_d) begin
                        addr_nxt  = bus.d_addr;
                        wdata_nxt = bus.d_wdata;
                        be_nxt    = bus.d_be;
                        if (!bus.d_we)
                            state_nxt = S_RD;
                        else if (bus.d_be == 4'h0)
                            state_nxt = S_DONE;
                        else
                            state_nxt = S_WR_SETUP;
                    end else begin
                        addr_nxt  = bus.if_addr;
                        be_nxt    = 4'hF;
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    cap_if    = !gnt_d;
                    cap_d     = gnt_d;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WR_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WR_HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WR_HOLD: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_RD: begin
                ce_n_nxt = 1'b0;
                oe_n_nxt = 1'b0;
                be_n_nxt = 4'h0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                ce_n_nxt  = 1'b0;
                be_n_nxt  = ~be_nxt;
                drive_nxt = 1'b1;
            end
            S_WR_PULSE: begin
                ce_n_nxt  = 1'b0;
                we_n_nxt  = 1'b0;
                be_n_nxt  = ~be_nxt;
                drive_nxt = 1'b1;
            end
            S_DONE: begin
                if_ack_nxt = !gnt_d_nxt;
                d_ack_nxt  = gnt_d_nxt;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, each with a small SRAM model.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(20)) ifc1 ();
    sram_port_arbiter_if #(.ADDR_W(20)) ifc3 ();

    wire  [31:0] sd1, sd3;
    logic [19:0] sa1, sa3;
    logic [3:0]  be1, be3;
    logic        ce1, oe1, we1, busy1;
    logic        ce3, oe3, we3, busy3;

    sram_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut1 (
        .clk_10M(clk), .reset_of_clk10M(rst), .bus(ifc1), .busy(busy1),
        .sram_data(sd1), .sram_addr(sa1), .sram_be_n(be1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

    sram_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(3)) dut3 (
        .clk_10M(clk), .reset_of_clk10M(rst), .bus(ifc3), .busy(busy3),
        .sram_data(sd3), .sram_addr(sa3), .sram_be_n(be3),
        .sram_ce_n(ce3), .sram_oe_n(oe3), .sram_we_n(we3));

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h3C08_0001;
        return {16'hA5A5, 8'(i), 8'(i)};
    endfunction

    // Asynchronous SRAM models: read while ce_n=0 and oe_n=0, byte-write on each we_n-low cycle.
    assign sd1 = (!ce1 && !oe1) ? mem1[sa1[7:0]] : 32'hzzzz_zzzz;
    assign sd3 = (!ce3 && !oe3) ? mem3[sa3[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
        end else if (!ce1 && !we1) begin
            for (int b = 0; b < 4; b++)
                if (!be1[b]) mem1[sa1[7:0]][8*b +: 8] <= sd1[8*b +: 8];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
        end else if (!ce3 && !we3) begin
            for (int b = 0; b < 4; b++)
                if (!be3[b]) mem3[sa3[7:0]][8*b +: 8] <= sd3[8*b +: 8];
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input bit sel3, input bit port_d, input bit req, input bit we,
                         input logic [19:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (sel3) begin
            ifc3.if_req = req && !port_d; ifc3.if_addr = addr;
            ifc3.d_req  = req && port_d;  ifc3.d_we = we; ifc3.d_addr = addr;
            ifc3.d_wdata = wdata;         ifc3.d_be = be;
        end else begin
            ifc1.if_req = req && !port_d; ifc1.if_addr = addr;
            ifc1.d_req  = req && port_d;  ifc1.d_we = we; ifc1.d_addr = addr;
            ifc1.d_wdata = wdata;         ifc1.d_be = be;
        end
    endtask

    // One transaction from an IDLE cycle (cycle 0) to its ack; measures latency and strobe activity.
    task automatic run_txn(input bit sel3, input bit port_d, input bit we, input logic [19:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int lat, output logic [31:0] rdata, output int we_low,
                           output int oe_low, output logic [3:0] be_seen, output logic ce0,
                           output int ovl);
        bit acked;
        logic ia, da, ce, oe, wen;
        logic [3:0] ben;
        logic [31:0] ird, drd;
        @(negedge clk);
        ce0 = sel3 ? ce3 : ce1;
        drive(sel3, port_d, 1'b1, we, addr, wdata, be);
        lat = 99; rdata = '0; we_low = 0; oe_low = 0; be_seen = 4'hF; ovl = 0; acked = 1'b0;
        for (int c = 1; c <= 40 && !acked; c++) begin
            @(negedge clk);
            ia  = sel3 ? ifc3.if_ack : ifc1.if_ack;
            da  = sel3 ? ifc3.d_ack : ifc1.d_ack;
            ce  = sel3 ? ce3 : ce1;
            oe  = sel3 ? oe3 : oe1;
            wen = sel3 ? we3 : we1;
            ben = sel3 ? be3 : be1;
            ird = sel3 ? ifc3.if_rdata : ifc1.if_rdata;
            drd = sel3 ? ifc3.d_rdata : ifc1.d_rdata;
            if (!ce && !oe)  begin oe_low++; be_seen = ben; end
            if (!ce && !wen) begin we_low++; be_seen = ben; end
            if (ia && da) ovl++;
            if (port_d ? da : ia) begin
                lat = c; rdata = port_d ? drd : ird; acked = 1'b1;
            end
        end
        drive(sel3, port_d, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
    endtask

    typedef struct packed {
        logic        port_d;
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_lat;
        logic [7:0]  exp_we_low;
        logic [7:0]  exp_oe_low;
        logic [3:0]  exp_be_n;
    } vec_t;

    vec_t vecs [10];

    int          lat, we_low, oe_low, ovl;
    logic [31:0] rdata;
    logic [3:0]  be_seen;
    logic        ce0;
    int          n_ack, ovl_cnt;
    logic [3:0]  order;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 20'h00010, 32'h0,         4'h0, 32'h3C08_0001, 8'd2, 8'd0, 8'd1, 4'h0};
        vecs[1] = '{1'b1, 1'b1, 20'h00020, 32'hDEAD_BEEF, 4'h3, 32'h0000_0000, 8'd4, 8'd1, 8'd0, 4'hC};
        vecs[2] = '{1'b1, 1'b0, 20'h00020, 32'h0,         4'hF, 32'hA5A5_BEEF, 8'd2, 8'd0, 8'd1, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 20'h00021, 32'h1234_5678, 4'h0, 32'hA5A5_BEEF, 8'd1, 8'd0, 8'd0, 4'hF};
        vecs[4] = '{1'b1, 1'b0, 20'h00021, 32'h0,         4'hF, 32'hA5A5_2121, 8'd2, 8'd0, 8'd1, 4'h0};
        vecs[5] = '{1'b1, 1'b1, 20'h00030, 32'hCAFE_F00D, 4'h8, 32'hA5A5_2121, 8'd4, 8'd1, 8'd0, 4'h7};
        vecs[6] = '{1'b1, 1'b0, 20'h00030, 32'h0,         4'hF, 32'hCAA5_3030, 8'd2, 8'd0, 8'd1, 4'h0};
        vecs[7] = '{1'b0, 1'b0, 20'h00030, 32'h0,         4'h0, 32'hCAA5_3030, 8'd2, 8'd0, 8'd1, 4'h0};
        vecs[8] = '{1'b1, 1'b1, 20'h00031, 32'h0123_4567, 4'hF, 32'hCAA5_3030, 8'd4, 8'd1, 8'd0, 4'h0};
        vecs[9] = '{1'b0, 1'b0, 20'h00031, 32'h0,         4'h0, 32'h0123_4567, 8'd2, 8'd0, 8'd1, 4'h0};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);

        // Reset and idle values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ce_n", 32'(ce1), 32'h1);
        check("rst_oe_n", 32'(oe1), 32'h1);
        check("rst_we_n", 32'(we1), 32'h1);
        check("rst_be_n", 32'(be1), 32'hF);
        check("rst_addr", 32'(sa1), 32'h0);
        check("rst_if_ack", 32'(ifc1.if_ack), 32'h0);
        check("rst_d_ack", 32'(ifc1.d_ack), 32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_if_rdata", ifc1.if_rdata, 32'h0);
        check("rst_d_rdata", ifc1.d_rdata, 32'h0);

        // Isolated transactions on the WAIT_CYCLES=1 instance.
        for (int v = 0; v < 10; v++) begin
            run_txn(1'b0, vecs[v].port_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be,
                    lat, rdata, we_low, oe_low, be_seen, ce0, ovl);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("v%0d_we_low", v), 32'(we_low), 32'(vecs[v].exp_we_low));
            check($sformatf("v%0d_oe_low", v), 32'(oe_low), 32'(vecs[v].exp_oe_low));
            check($sformatf("v%0d_be_n", v), 32'(be_seen), 32'(vecs[v].exp_be_n));
            check($sformatf("v%0d_ce_idle", v), 32'(ce0), 32'h1);
            check($sformatf("v%0d_ack_overlap", v), 32'(ovl), 32'h0);
        end

        // Contention from reset: both requesters held high, expect DATA, IF, DATA, IF.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ifc1.if_req = 1'b1; ifc1.if_addr = 20'h00010;
        ifc1.d_req = 1'b1;  ifc1.d_we = 1'b0; ifc1.d_addr = 20'h00005; ifc1.d_be = 4'hF;
        n_ack = 0; ovl_cnt = 0; order = 4'h0;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            @(negedge clk);
            if (ifc1.if_ack && ifc1.d_ack) ovl_cnt++;
            if (ifc1.d_ack) begin
                order[n_ack] = 1'b1;
                check($sformatf("cont%0d_d_rdata", n_ack), ifc1.d_rdata, 32'hA5A5_0505);
                n_ack++;
            end else if (ifc1.if_ack) begin
                order[n_ack] = 1'b0;
                check($sformatf("cont%0d_if_rdata", n_ack), ifc1.if_rdata, 32'h3C08_0001);
                n_ack++;
            end
        end
        ifc1.if_req = 1'b0; ifc1.d_req = 1'b0;
        check("cont_grants", 32'(n_ack), 32'd4);
        check("cont_order", 32'(order), 32'h5);
        check("cont_overlap", 32'(ovl_cnt), 32'h0);

        // Reset asserted during WR_PULSE: strobes released at once, no ack afterwards.
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 20'h00040, 32'h55AA_55AA, 4'hF);
        repeat (2) @(negedge clk);
        check("pulse_we_low", 32'(we1), 32'h0);
        rst = 1'b1;
        #1;
        check("rst_mid_we_n", 32'(we1), 32'h1);
        check("rst_mid_ce_n", 32'(ce1), 32'h1);
        check("rst_mid_busy", 32'(busy1), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        rst = 1'b0;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc1.d_ack || ifc1.if_ack) n_ack++;
        end
        check("rst_mid_no_ack", 32'(n_ack), 32'h0);

        // WAIT_CYCLES=3: back-to-back data reads, then a full write and its readback.
        run_txn(1'b1, 1'b1, 1'b0, 20'h00007, 32'h0, 4'hF, lat, rdata, we_low, oe_low, be_seen, ce0, ovl);
        check("w3_rd0_latency", 32'(lat), 32'd4);
        check("w3_rd0_rdata", rdata, 32'hA5A5_0707);
        check("w3_rd0_oe_low", 32'(oe_low), 32'd3);
        check("w3_rd0_we_low", 32'(we_low), 32'd0);
        run_txn(1'b1, 1'b1, 1'b0, 20'h00008, 32'h0, 4'hF, lat, rdata, we_low, oe_low, be_seen, ce0, ovl);
        check("w3_rd1_latency", 32'(lat), 32'd4);
        check("w3_rd1_rdata", rdata, 32'hA5A5_0808);
        check("w3_rd1_oe_low", 32'(oe_low), 32'd3);
        check("w3_rd1_ce_gap", 32'(ce0), 32'h1);
        run_txn(1'b1, 1'b1, 1'b1, 20'h00009, 32'h8765_4321, 4'hF, lat, rdata, we_low, oe_low, be_seen, ce0, ovl);
        check("w3_wr_latency", 32'(lat), 32'd6);
        check("w3_wr_we_low", 32'(we_low), 32'd3);
        check("w3_wr_rdata_kept", rdata, 32'hA5A5_0808);
        run_txn(1'b1, 1'b1, 1'b0, 20'h00009, 32'h0, 4'hF, lat, rdata, we_low, oe_low, be_seen, ce0, ovl);
        check("w3_rb_rdata", rdata, 32'h8765_4321);
        check("w3_rb_latency", 32'(lat), 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
